// File: rtl/can_pkg.sv
// Shared CAN constants and types used by the TX CRC generator and the RX CRC checker.
package can_pkg;

    localparam int               CAN_CRC_WIDTH = 15;
    localparam logic [14:0]      CAN_CRC_POLY  = 15'h4599;
    localparam logic [14:0]      CAN_CRC_INIT  = 15'h0000;
    localparam logic             CAN_RECESSIVE = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCUM    = 2'd1,
        SEND_CRC = 2'd2,
        DELIM    = 2'd3
    } crc_tx_state_t;

endpackage

// File: rtl/crc15_lfsr.sv
// Serial CRC register: load an initial value or fold one bit per enabled cycle.
module crc15_lfsr
    import can_pkg::*;
#(
    parameter int                 WIDTH = CAN_CRC_WIDTH,
    parameter logic [WIDTH-1:0]   POLY  = CAN_CRC_POLY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] init_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] crc_o
);

    logic [WIDTH-1:0] crc_q;
    logic [WIDTH-1:0] crc_d;

    function automatic logic [WIDTH-1:0] crc_step(input logic [WIDTH-1:0] crc, input logic b);
        logic nxt;
        nxt = b ^ crc[WIDTH-1];
        return {crc[WIDTH-2:0], 1'b0} ^ (nxt ? POLY : {WIDTH{1'b0}});
    endfunction

    // Next CRC value: load wins over fold
    always_comb begin
        if (load_i) begin
            crc_d = init_i;
        end else if (en_i) begin
            crc_d = crc_step(crc_q, bit_i);
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= {WIDTH{1'b0}};
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/can_crc_tx.sv
// CAN transmit CRC: folds frame bits into CRC-15, then serialises the CRC and its delimiter.
module can_crc_tx
    import can_pkg::*;
#(
    parameter int                     CRC_WIDTH = CAN_CRC_WIDTH,
    parameter logic [CRC_WIDTH-1:0]   CRC_POLY  = CAN_CRC_POLY,
    parameter logic [CRC_WIDTH-1:0]   CRC_INIT  = CAN_CRC_INIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_tick,
    input  logic                 stall,
    input  logic                 start,
    input  logic                 data_bit,
    input  logic                 crc_send,
    input  logic                 abort,
    output logic                 txd,
    output logic [CRC_WIDTH-1:0] crc_value,
    output logic                 in_crc_field,
    output logic                 busy,
    output logic                 done
);

    localparam int               CNT_W    = $clog2(CRC_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRC_WIDTH - 1);

    crc_tx_state_t        state_q, state_d;
    logic [CRC_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 txd_q, txd_d;
    logic                 in_crc_q, in_crc_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 adv_s;
    logic                 lfsr_load_s;
    logic                 lfsr_en_s;

    assign adv_s = bit_tick & ~stall;

    crc15_lfsr #(
        .WIDTH (CRC_WIDTH),
        .POLY  (CRC_POLY)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load_i (lfsr_load_s),
        .init_i (CRC_INIT),
        .en_i   (lfsr_en_s),
        .bit_i  (data_bit),
        .crc_o  (crc_value)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort and start override the per-state transitions
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                IDLE:     state_d = IDLE;
                ACCUM:    state_d = crc_send ? SEND_CRC : ACCUM;
                SEND_CRC: state_d = (adv_s && (cnt_q == CNT_ZERO)) ? DELIM : SEND_CRC;
                DELIM:    state_d = adv_s ? IDLE : DELIM;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Datapath and output next values; crc_send in ACCUM snapshots the CRC without folding data_bit
    always_comb begin
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        txd_d       = txd_q;
        done_d      = 1'b0;
        lfsr_load_s = 1'b0;
        lfsr_en_s   = 1'b0;
        if (abort) begin
            txd_d = CAN_RECESSIVE;
            cnt_d = CNT_ZERO;
        end else if (start) begin
            lfsr_load_s = 1'b1;
            txd_d       = CAN_RECESSIVE;
            cnt_d       = CNT_ZERO;
        end else begin
            case (state_q)
                IDLE: begin
                    txd_d = CAN_RECESSIVE;
                end
                ACCUM: begin
                    if (crc_send) begin
                        shreg_d = crc_value;
                        cnt_d   = CNT_LAST;
                        txd_d   = crc_value[CRC_WIDTH-1];
                    end else if (adv_s) begin
                        lfsr_en_s = 1'b1;
                        txd_d     = data_bit;
                    end else begin
                        txd_d = txd_q;
                    end
                end
                SEND_CRC: begin
                    if (adv_s && (cnt_q != CNT_ZERO)) begin
                        shreg_d = {shreg_q[CRC_WIDTH-2:0], shreg_q[CRC_WIDTH-1]};
                        cnt_d   = cnt_q - CNT_ONE;
                        txd_d   = shreg_q[CRC_WIDTH-2];
                    end else if (adv_s) begin
                        txd_d = CAN_RECESSIVE;
                    end else begin
                        txd_d = txd_q;
                    end
                end
                DELIM: begin
                    txd_d  = CAN_RECESSIVE;
                    done_d = adv_s;
                end
                default: begin
                    txd_d = CAN_RECESSIVE;
                end
            endcase
        end
        in_crc_d = (state_d == SEND_CRC);
        busy_d   = (state_d != IDLE);
    end

    // Output and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q  <= {CRC_WIDTH{1'b0}};
            cnt_q    <= CNT_ZERO;
            txd_q    <= CAN_RECESSIVE;
            in_crc_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            txd_q    <= txd_d;
            in_crc_q <= in_crc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign txd          = txd_q;
    assign in_crc_field = in_crc_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_can_crc_tx.sv
// Self-checking bench for can_crc_tx: directed vectors plus random frames against a polynomial-division model.
module tb_can_crc_tx;
    import can_pkg::*;

    logic        clk = 1'b0;
    logic        rst, bit_tick, stall, start, data_bit, crc_send, abort;
    logic        txd, in_crc_field, busy, done;
    logic [14:0] crc_value;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          n;
        logic [63:0] bits;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[4];

    can_crc_tx dut (
        .clk          (clk),
        .rst          (rst),
        .bit_tick     (bit_tick),
        .stall        (stall),
        .start        (start),
        .data_bit     (data_bit),
        .crc_send     (crc_send),
        .abort        (abort),
        .txd          (txd),
        .crc_value    (crc_value),
        .in_crc_field (in_crc_field),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic b, input logic st);
        data_bit = b;
        bit_tick = 1'b1;
        stall    = st;
        step();
        bit_tick = 1'b0;
        stall    = 1'b0;
    endtask

    // CRC as the remainder of message*x^15 divided by x^15+0x4599 (long division, zero init)
    function automatic logic [14:0] model_crc(input int n, input logic [63:0] bits);
        int unsigned rem = 0;
        for (int i = 0; i < n + 15; i++) begin
            rem = (rem << 1) | ((i < n) ? 32'(bits[i]) : 32'd0);
            if ((rem & 32'h8000) != 32'd0) rem = rem ^ 32'hC599;
        end
        return rem[14:0];
    endfunction

    task automatic run_frame(input int n, input logic [63:0] bits, input logic [14:0] exp,
                             input int stall_pct, input logic [15:0] smask,
                             input int abort_at, input logic same_tick);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_crc", 32'(crc_value), 32'd0);
        step();
        for (int i = 0; i < n; i++) begin
            if (int'($urandom_range(99)) < stall_pct) begin
                tick(1'($urandom_range(1)), 1'b1);
                step();
            end
            tick(bits[i], 1'b0);
            chk("accum_txd", 32'(txd), 32'(bits[i]));
            step();
        end
        chk("accum_crc", 32'(crc_value), 32'(exp));
        crc_send = 1'b1;
        bit_tick = same_tick;
        data_bit = 1'b1;
        step();
        crc_send = 1'b0;
        bit_tick = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk("crc_field", 32'(in_crc_field), 32'd1);
            chk("crc_txd", 32'(txd), 32'(exp[14-i]));
            if (i == abort_at) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                chk("abort_txd", 32'(txd), 32'd1);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_field", 32'(in_crc_field), 32'd0);
                for (int k = 0; k < 4; k++) begin
                    tick(1'b0, 1'b0);
                    chk("abort_no_done", 32'(done), 32'd0);
                    step();
                end
                return;
            end
            if (smask[i]) begin
                tick(1'b0, 1'b1);
                chk("stall_txd", 32'(txd), 32'(exp[14-i]));
                chk("stall_field", 32'(in_crc_field), 32'd1);
                step();
            end
            tick(1'b0, 1'b0);
            step();
        end
        chk("delim_txd", 32'(txd), 32'd1);
        chk("delim_field", 32'(in_crc_field), 32'd0);
        chk("delim_busy", 32'(busy), 32'd1);
        chk("delim_done", 32'(done), 32'd0);
        chk("crc_frozen", 32'(crc_value), 32'(exp));
        if (smask[15]) begin
            tick(1'b0, 1'b1);
            chk("delim_stall_done", 32'(done), 32'd0);
            chk("delim_stall_busy", 32'(busy), 32'd1);
            step();
        end
        tick(1'b0, 1'b0);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_txd", 32'(txd), 32'd1);
        step();
        chk("done_once", 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; bit_tick = 1'b0; stall = 1'b0; start = 1'b0;
        data_bit = 1'b0; crc_send = 1'b0; abort = 1'b0;
        tbl[0] = '{n: 1, bits: 64'h1, exp: 15'h4599};
        tbl[1] = '{n: 2, bits: 64'h1, exp: 15'h4EAB};
        tbl[2] = '{n: 3, bits: 64'h0, exp: 15'h0000};
        tbl[3] = '{n: 2, bits: 64'h2, exp: 15'h4EAB ^ 15'h4599 ^ 15'h4599 ^ 15'h4EAB ^ 15'h4599};

        // Reset values
        step(); step();
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_crc", 32'(crc_value), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_field", 32'(in_crc_field), 32'd0);
        rst = 1'b0;
        step();

        // Reset mid-ACCUM, asynchronous
        start = 1'b1; step(); start = 1'b0;
        tick(1'b1, 1'b0); step();
        tick(1'b0, 1'b0); step();
        chk("pre_rst_crc", 32'(crc_value), 32'h4EAB);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_txd", 32'(txd), 32'd1);
        chk("async_rst_crc", 32'(crc_value), 32'd0);
        step(); step();
        rst = 1'b0;
        step();
        chk("mid_rst_txd", 32'(txd), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_crc", 32'(crc_value), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);

        // crc_send in IDLE is ignored
        crc_send = 1'b1; step(); crc_send = 1'b0;
        chk("idle_send_busy", 32'(busy), 32'd0);
        chk("idle_send_field", 32'(in_crc_field), 32'd0);

        // Directed vector table
        for (int v = 0; v < 4; v++) begin
            run_frame(tbl[v].n, tbl[v].bits, tbl[v].exp, 0, 16'h0000, -1, 1'b0);
            step();
        end

        // Stalls during SEND_CRC and in DELIM
        run_frame(2, 64'h1, 15'h4EAB, 0, 16'h8224, -1, 1'b0);
        step();

        // Abort at CRC bit 7, then a fresh frame
        run_frame(2, 64'h1, 15'h4EAB, 0, 16'h0000, 7, 1'b0);
        run_frame(1, 64'h1, 15'h4599, 0, 16'h0000, -1, 1'b0);
        step();

        // crc_send coinciding with bit_tick does not fold data_bit
        run_frame(1, 64'h1, 15'h4599, 0, 16'h0000, -1, 1'b1);
        step();

        // Restart with start while in SEND_CRC
        start = 1'b1; step(); start = 1'b0;
        tick(1'b0, 1'b0); step();
        crc_send = 1'b1; step(); crc_send = 1'b0;
        tick(1'b0, 1'b0); step();
        start = 1'b1; step(); start = 1'b0;
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_field", 32'(in_crc_field), 32'd0);
        tick(1'b1, 1'b0); step();
        chk("restart_crc", 32'(crc_value), 32'h4599);
        abort = 1'b1; step(); abort = 1'b0;
        chk("restart_abort_crc_kept", 32'(crc_value), 32'h4599);
        step();

        // Random frames with random stalls
        for (int r = 0; r < 20; r++) begin
            int          n;
            logic [63:0] bits;
            n    = int'($urandom_range(40, 1));
            bits = {$urandom, $urandom};
            run_frame(n, bits, model_crc(n, bits), 20, 16'($urandom_range(16'hFFFF)), -1, 1'b0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
